// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the SEQ Y86-64 core: owns the PC, steps F/D/E/M/W/PC-update,
// handshakes with data memory and tracks processor status and retired-instruction count.
module seq_stage_ctrl #(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int unsigned COUNT_W     = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               run_i,
  input  logic [3:0]         icode_i,
  input  logic               instr_valid_i,
  input  logic               imem_error_i,
  input  logic               cnd_i,
  input  logic [63:0]        valc_i,
  input  logic [63:0]        valp_i,
  input  logic [63:0]        valm_i,
  input  logic               mem_ack_i,
  input  logic               dmem_error_i,
  output logic [63:0]        pc_o,
  output logic               fetch_en_o,
  output logic               decode_en_o,
  output logic               execute_en_o,
  output logic               memory_en_o,
  output logic               writeback_en_o,
  output logic               mem_req_o,
  output logic               pc_we_o,
  output logic [2:0]         stat_o,
  output logic               halted_o,
  output logic [COUNT_W-1:0] instr_count_o
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExecute, StMemory, StWriteback, StPcUpdate, StHalt
  } state_e;

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;
  // Last MEMORY cycle (wait count) in which an ack is still accepted.
  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e             state_q;
  logic [63:0]        pc_q;
  logic [63:0]        valm_q;
  logic [3:0]         icode_q;
  logic               cnd_q;
  logic [2:0]         stat_q;
  logic [7:0]         wait_q;
  logic [COUNT_W-1:0] count_q;

  logic        uses_mem;
  logic [63:0] next_pc;

  assign uses_mem = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

  always_comb begin
    next_pc = valp_i;
    if (icode_q == 4'h8) begin
      next_pc = valc_i;
    end else if (icode_q == 4'h7 && cnd_q) begin
      next_pc = valc_i;
    end else if (icode_q == 4'h9) begin
      next_pc = valm_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      valm_q  <= '0;
      icode_q <= '0;
      cnd_q   <= 1'b0;
      stat_q  <= StatAok;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (run_i) state_q <= StFetch;
        end
        StFetch: begin
          if (imem_error_i) begin
            stat_q  <= StatAdr;
            state_q <= StHalt;
          end else if (!instr_valid_i) begin
            stat_q  <= StatIns;
            state_q <= StHalt;
          end else if (icode_i == 4'h0) begin
            // halt retires but leaves the PC pointing at itself
            stat_q  <= StatHlt;
            count_q <= count_q + COUNT_W'(1);
            state_q <= StHalt;
          end else begin
            icode_q <= icode_i;
            state_q <= StDecode;
          end
        end
        StDecode: state_q <= StExecute;
        StExecute: begin
          cnd_q   <= cnd_i;
          wait_q  <= '0;
          state_q <= uses_mem ? StMemory : StWriteback;
        end
        StMemory: begin
          if (mem_ack_i) begin
            if (dmem_error_i) begin
              stat_q  <= StatAdr;
              state_q <= StHalt;
            end else begin
              valm_q  <= valm_i;
              state_q <= StWriteback;
            end
          end else if (wait_q == WaitLast) begin
            stat_q  <= StatAdr;
            state_q <= StHalt;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StWriteback: state_q <= StPcUpdate;
        StPcUpdate: begin
          pc_q    <= next_pc;
          count_q <= count_q + COUNT_W'(1);
          state_q <= run_i ? StFetch : StIdle;
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fetch_en_o     = (state_q == StFetch);
  assign decode_en_o    = (state_q == StDecode);
  assign execute_en_o   = (state_q == StExecute);
  assign memory_en_o    = (state_q == StMemory);
  assign writeback_en_o = (state_q == StWriteback);
  assign mem_req_o      = (state_q == StMemory);
  assign pc_we_o        = (state_q == StPcUpdate);
  assign halted_o       = (state_q == StHalt);
  assign pc_o           = pc_q;
  assign stat_o         = stat_q;
  assign instr_count_o  = count_q;

endmodule
